// File: rtl/inst_prefetch_buf.sv
// Four-entry instruction/PC+4 FIFO between fetch and decode; a pushed entry is visible one cycle later.
// Backpressure: in_ready drops when full (no pop-to-push bypass); flush and reset empty the buffer in one edge.
module inst_prefetch_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc_plus_4,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc_plus_4,
    input  logic        out_ready,
    input  logic        flush,
    output logic [2:0]  count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    entry_t     r_mem [DEPTH];
    logic [1:0] r_head;
    logic [1:0] r_tail;
    logic [2:0] r_count;

    logic   w_push;
    logic   w_pop;
    entry_t w_head_ent;

    assign in_ready   = (r_count != FULL_CNT);
    assign out_valid  = (r_count != 3'd0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_head_ent = r_mem[r_head];

    // Gate the head data so decode never sees stale words from an empty buffer.
    assign out_instruction = out_valid ? w_head_ent.instr : 32'h0;
    assign out_pc_plus_4   = out_valid ? w_head_ent.pc4   : 32'h0;
    assign count           = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= '{instr: in_instruction, pc4: in_pc_plus_4};
                r_tail        <= r_tail + 2'd1;
            end
            if (w_pop) begin
                r_head <= r_head + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

endmodule

// File: doc/inst_prefetch_buf.md
INST_PREFETCH_BUF -- requirements
Module: inst_prefetch_buf

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of buffered fetch entries; only 4 is supported.
REQ-002 The module SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 The module SHALL have port in_instruction  input  32  instruction word from the fetch stage.
REQ-006 The module SHALL have port in_pc_plus_4  input  32  PC+4 belonging to in_instruction.
REQ-007 The module SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 The module SHALL have port out_valid  output  1  head entry available to decode.
REQ-009 The module SHALL have port out_instruction  output  32  head instruction word.
REQ-010 The module SHALL have port out_pc_plus_4  output  32  head PC+4.
REQ-011 The module SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-012 The module SHALL have port flush  input  1  branch/jump redirect; discard all entries.
REQ-013 The module SHALL have port count  output  3  number of valid entries, 0..4.

Function
REQ-014 Push SHALL occur when in_valid=1 and in_ready=1; the entry {in_instruction, in_pc_plus_4} is written at the tail pointer and tail advances by 1.
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1; head advances by 1.
REQ-016 Head and tail pointers SHALL be 2 bits and wrap 3 -> 0.
REQ-017 in_ready SHALL equal (count != 4), combinationally from registered state only; no same-cycle pop-to-push bypass.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 out_instruction and out_pc_plus_4 SHALL show the head entry when out_valid=1 and SHALL be 32'h0 when out_valid=0.
REQ-020 Push-to-output latency SHALL be 1 cycle: an entry pushed into an empty buffer at edge N is presented with out_valid=1 in the cycle after edge N.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 count SHALL update next cycle by +1 on push only, -1 on pop only, 0 otherwise.
REQ-023 When full (count=4), in_valid SHALL be ignored, and stored data and tail SHALL be unchanged.
REQ-024 When empty, out_ready SHALL be ignored and head SHALL be unchanged.
REQ-025 flush=1 at an edge SHALL set head=0, tail=0, count=0, discarding any same-cycle push and pop; stored data words need not be cleared.
REQ-026 The cycle after a flush, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-027 Entries SHALL never be duplicated, dropped (except by flush/reset), or reordered.

Reset
REQ-028 reset=1 at a rising edge SHALL set head=0, tail=0, count=0 and clear all storage to 0.
REQ-029 Reset SHALL take priority over flush, push and pop in the same cycle.
REQ-030 During and after reset: out_valid=0, in_ready=1, count=0, out_instruction=0, out_pc_plus_4=0.
REQ-031 Reset asserted mid-operation with a full buffer SHALL empty it in one edge; nothing pushed in that cycle is retained.

Verification
REQ-032 Reset then push 0x20080005/PC+4=0x4 with out_ready=0 -> next cycle out_valid=1, out_instruction=0x20080005, out_pc_plus_4=0x4, count=1.
REQ-033 Push 5 consecutive words (PC+4 = 4,8,12,16,20) with out_ready=0 -> count=4 after 4 pushes, in_ready=0, 5th word dropped; then pop 4 words in order 4,8,12,16 -> out_valid=0, count=0.
REQ-034 Fill to 2 entries, then 6 cycles with push and pop together -> count stays 2, outputs PC+4 sequence strictly increasing by 4, pointers wrap past 3 with no data loss.
REQ-035 Count=3 with flush=1, in_valid=1, out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, out_instruction=0, in_ready=1; next push appears alone at head.
REQ-036 Full buffer with reset=1 and flush=1 and in_valid=1 in the same cycle -> next cycle count=0, all outputs 0 except in_ready=1.
REQ-037 Random in_valid/out_ready/flush for 10000 cycles against a reference queue model -> every popped {instruction, PC+4} matches model order; count never exceeds 4.
